styler_sequencer: RTL and testbench

Sequences one character cell through the combinational scanline styler, row by row. On a start pulse it latches a glyph code, attribute word and control bits. For each scanline it fetches the glyph row from font memory over a req/ack handshake, presents the row to the styler, registers the styled result and hands it downstream over valid/ready. It also generates the faint, blink and cursor phase signals from a frame counter.

---
 rtl/styler_pkg.sv | 15 +
 rtl/styler_sequencer_if.sv | 26 ++
 rtl/styler_phase_gen.sv | 31 +++
 rtl/styler_sequencer.sv | 126 ++++++++++++
 tb/tb_styler_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/styler_pkg.sv
// Shared types and constants for the scanline styler sequencer.
// No logic; latency and backpressure are defined by the users of these types.
package styler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STYLE = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [5:0] CTRL_RST = 6'h3C;
  localparam int         ATTR_W   = 25;

endpackage

// File: rtl/styler_sequencer_if.sv
// Font-fetch req/ack and styled-row valid/ready bundle between the sequencer and its neighbours.
// Font side holds req until ack; row side holds valid and data until ready.
interface styler_sequencer_if #(
  parameter int CODE_W = 8
);

  logic              font_req;
  logic [CODE_W+3:0] font_addr;
  logic              font_ack;
  logic [15:0]       font_data;
  logic              out_valid;
  logic [3:0]        out_row;
  logic [15:0]       out_data;
  logic              out_ready;

  modport master (
    output font_req, font_addr, out_valid, out_row, out_data,
    input  font_ack, font_data, out_ready
  );

  modport slave (
    input  font_req, font_addr, out_valid, out_row, out_data,
    output font_ack, font_data, out_ready
  );

endinterface

// File: rtl/styler_phase_gen.sv
// Frame counter and faint/blink/cursor phases; phases follow the counter with no added delay.
// Counter advances on every frame tick regardless of sequencer state; no backpressure.
module styler_phase_gen #(
  parameter int BLINK_BIT  = 4,
  parameter int CURSOR_BIT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_frame_tick,
  input  logic i_scan_lsb,
  output logic o_faint,
  output logic o_blink,
  output logic o_cursor
);

  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (i_frame_tick) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Faint alternates by frame and by scanline so it dithers on both axes.
  assign o_faint  = r_frame_cnt[0] ^ i_scan_lsb;
  assign o_blink  = r_frame_cnt[BLINK_BIT];
  assign o_cursor = r_frame_cnt[CURSOR_BIT];

endmodule

// File: rtl/styler_sequencer.sv
// Walks one character cell through the styler row by row: fetch, style, hand off; 3 cycles/row unstalled.
// Font waits stretch FETCH; out_ready low holds the row in OUT and stops the next fetch.
module styler_sequencer
  import styler_pkg::*;
#(
  parameter int ROWS       = 16,
  parameter int CODE_W     = 8,
  parameter int BLINK_BIT  = 4,
  parameter int CURSOR_BIT = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic [CODE_W-1:0]  i_code,
  input  logic [ATTR_W-1:0]  i_attr_in,
  input  logic [5:0]         i_ctrl_in,
  output logic               o_busy,
  output logic               o_done,
  output logic [3:0]         o_sty_scanline,
  output logic [15:0]        o_sty_bitmap,
  output logic [ATTR_W-1:0]  o_sty_attr,
  output logic [5:0]         o_sty_ctrl,
  output logic               o_sty_faint,
  output logic               o_sty_blink,
  output logic               o_sty_cursor,
  input  logic [3:0]         i_sty_scanline_out,
  input  logic [15:0]        i_sty_bitmap_out,
  styler_sequencer_if.master bus
);

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CODE_W-1:0]  r_code;
  logic [ATTR_W-1:0]  r_attr;
  logic [5:0]         r_ctrl;
  logic [3:0]         r_scanline;
  logic [15:0]        r_bitmap;
  logic [15:0]        r_out_data;
  logic [3:0]         r_out_row;
  logic               w_font_hs;
  logic               w_out_hs;
  logic               w_last;

  assign w_font_hs = (r_state == FETCH) && bus.font_ack;
  assign w_out_hs  = (r_state == OUT) && bus.out_ready;
  assign w_last    = (r_scanline == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = FETCH;
      FETCH:   if (bus.font_ack) w_state_nxt = STYLE;
      STYLE:   w_state_nxt = OUT;
      OUT:     if (bus.out_ready) w_state_nxt = w_last ? IDLE : FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code     <= '0;
      r_attr     <= '0;
      r_ctrl     <= CTRL_RST;
      r_scanline <= '0;
      r_bitmap   <= '0;
      r_out_data <= '0;
      r_out_row  <= '0;
    end else begin
      if ((r_state == IDLE) && i_start) begin
        r_code     <= i_code;
        r_attr     <= i_attr_in;
        r_ctrl     <= i_ctrl_in;
        r_scanline <= '0;
      end
      if (w_font_hs) begin
        r_bitmap <= bus.font_data;
      end
      // Styler is combinational; its result is sampled at the end of the STYLE cycle.
      if (r_state == STYLE) begin
        r_out_data <= i_sty_bitmap_out;
        r_out_row  <= i_sty_scanline_out;
      end
      if (w_out_hs && !w_last) begin
        r_scanline <= r_scanline + 4'd1;
      end
    end
  end

  styler_phase_gen #(
    .BLINK_BIT  (BLINK_BIT),
    .CURSOR_BIT (CURSOR_BIT)
  ) u_phase (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_tick (i_frame_tick),
    .i_scan_lsb   (r_scanline[0]),
    .o_faint      (o_sty_faint),
    .o_blink      (o_sty_blink),
    .o_cursor     (o_sty_cursor)
  );

  assign o_busy         = (r_state != IDLE);
  assign o_done         = w_out_hs && w_last;
  assign o_sty_scanline = r_scanline;
  assign o_sty_bitmap   = r_bitmap;
  assign o_sty_attr     = r_attr;
  assign o_sty_ctrl     = r_ctrl;

  assign bus.font_req   = (r_state == FETCH);
  assign bus.font_addr  = {r_code, r_scanline};
  assign bus.out_valid  = (r_state == OUT);
  assign bus.out_row    = r_out_row;
  assign bus.out_data   = r_out_data;

endmodule

// File: tb/tb_styler_sequencer.sv
// Randomized and directed stimulus for styler_sequencer, checked every cycle against a
// transaction-level model of rows fetched, styled and accepted.
module tb_styler_sequencer;
  import styler_pkg::*;

  localparam int ROWS   = 16;
  localparam int CODE_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        frame_tick = 1'b0;
  logic        start      = 1'b0;
  logic [7:0]  code       = '0;
  logic [24:0] attr_in    = '0;
  logic [5:0]  ctrl_in    = '0;
  logic        busy, done;
  logic [3:0]  sty_scanline, sty_scanline_out;
  logic [15:0] sty_bitmap, sty_bitmap_out;
  logic [24:0] sty_attr;
  logic [5:0]  sty_ctrl;
  logic        sty_faint, sty_blink, sty_cursor;

  styler_sequencer_if #(.CODE_W(CODE_W)) bus ();

  styler_sequencer #(
    .ROWS(ROWS), .CODE_W(CODE_W), .BLINK_BIT(4), .CURSOR_BIT(5)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_frame_tick       (frame_tick),
    .i_start            (start),
    .i_code             (code),
    .i_attr_in          (attr_in),
    .i_ctrl_in          (ctrl_in),
    .o_busy             (busy),
    .o_done             (done),
    .o_sty_scanline     (sty_scanline),
    .o_sty_bitmap       (sty_bitmap),
    .o_sty_attr         (sty_attr),
    .o_sty_ctrl         (sty_ctrl),
    .o_sty_faint        (sty_faint),
    .o_sty_blink        (sty_blink),
    .o_sty_cursor       (sty_cursor),
    .i_sty_scanline_out (sty_scanline_out),
    .i_sty_bitmap_out   (sty_bitmap_out),
    .bus                (bus)
  );

  function automatic logic [15:0] font_fn(input logic [7:0] c, input logic [3:0] r);
    logic [7:0] lo;
    lo = c + 8'(r) * 8'd3;
    return {c ^ {r, r}, lo};
  endfunction

  // Stand-in styler: mixes attributes and phases so captured rows reveal timing errors.
  assign sty_bitmap_out   = sty_bitmap ^ sty_attr[15:0] ^ {13'b0, sty_blink, sty_cursor, sty_faint};
  assign sty_scanline_out = sty_scanline ^ sty_attr[19:16];

  int   ack_delay = 0;
  int   req_age   = 0;
  int   vld_age   = 0;
  int   bp_row    = -1;
  int   bp_len    = 0;
  logic stray_ack = 1'b0;
  logic rdy_base  = 1'b1;
  bit   rand_en   = 1'b0;

  assign bus.font_ack  = bus.font_req ? (req_age >= ack_delay) : stray_ack;
  assign bus.font_data = bus.font_ack ? font_fn(bus.font_addr[11:4], bus.font_addr[3:0]) : 16'hDEAD;
  assign bus.out_ready = rdy_base && !(bus.out_valid && (int'(bus.out_row) == bp_row) && (vld_age < bp_len));

  always @(posedge clk) begin
    req_age <= (bus.font_req && !bus.font_ack) ? req_age + 1 : 0;
    vld_age <= (bus.out_valid && !bus.out_ready) ? vld_age + 1 : 0;
  end

  int checks = 0, errors = 0, cyc = 0, dut_dones = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: what has been fetched, styled and accepted, plus the frame count.
  bit          m_active = 0, m_have_row = 0;
  int          m_ack_cyc = 0, m_start_cyc = 0, m_done_cyc = 0, m_rows = 0;
  logic [3:0]  m_row = '0, m_exp_row = '0;
  logic [7:0]  m_code = '0, m_cnt = '0;
  logic [24:0] m_attr = '0;
  logic [5:0]  m_ctrl = CTRL_RST;
  logic [15:0] m_exp_data = '0;
  logic [11:0] addr_log[$];

  always @(negedge clk) begin : mon
    logic ph_b, ph_c, ph_f, exp_req, exp_vld, exp_done;
    if (done) dut_dones++;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_font_req", bus.font_req, 0);
      chk("rst_font_addr", bus.font_addr, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", {bus.out_row, bus.out_data}, 0);
      chk("rst_sty_data", {sty_scanline, sty_bitmap, sty_attr}, 0);
      chk("rst_sty_ctrl", sty_ctrl, 6'h3C);
      chk("rst_phases", {sty_faint, sty_blink, sty_cursor}, 0);
      m_active = 0; m_have_row = 0; m_row = '0; m_code = '0;
      m_attr = '0; m_ctrl = CTRL_RST; m_cnt = '0;
    end else begin
      ph_b = m_cnt[4];
      ph_c = m_cnt[5];
      ph_f = m_cnt[0] ^ m_row[0];
      chk("blink", sty_blink, ph_b);
      chk("cursor", sty_cursor, ph_c);
      chk("faint", sty_faint, ph_f);
      exp_req  = m_active && !m_have_row;
      exp_vld  = m_have_row && (cyc >= m_ack_cyc + 2);
      exp_done = exp_vld && bus.out_ready && (m_row == 4'(ROWS - 1));
      chk("busy", busy, m_active);
      chk("font_req", bus.font_req, exp_req);
      chk("font_addr", bus.font_addr, {m_code, m_row});
      chk("out_valid", bus.out_valid, exp_vld);
      chk("done", done, exp_done);
      chk("sty_scanline", sty_scanline, m_row);
      chk("sty_attr", sty_attr, m_attr);
      chk("sty_ctrl", sty_ctrl, m_ctrl);
      if (m_have_row && (cyc == m_ack_cyc + 1)) begin
        chk("sty_bitmap", sty_bitmap, font_fn(m_code, m_row));
        m_exp_data = font_fn(m_code, m_row) ^ m_attr[15:0] ^ {13'b0, ph_b, ph_c, ph_f};
        m_exp_row  = m_row ^ m_attr[19:16];
      end
      if (exp_vld) begin
        chk("out_data", bus.out_data, m_exp_data);
        chk("out_row", bus.out_row, m_exp_row);
      end
      if (frame_tick) m_cnt = m_cnt + 8'd1;
      if (!m_active && start) begin
        m_active = 1; m_have_row = 0; m_row = '0; m_rows = 0;
        m_code = code; m_attr = attr_in; m_ctrl = ctrl_in; m_start_cyc = cyc;
      end else if (exp_req && bus.font_ack) begin
        m_have_row = 1; m_ack_cyc = cyc;
        addr_log.push_back({m_code, m_row});
      end else if (exp_vld && bus.out_ready) begin
        m_rows++;
        m_have_row = 0;
        if (m_row == 4'(ROWS - 1)) begin
          m_active = 0; m_done_cyc = cyc;
        end else begin
          m_row = m_row + 4'd1;
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    frame_tick = 1'b0;
    if (rand_en) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      rdy_base   = ($urandom_range(0, 3) != 0);
      stray_ack  = 1'($urandom_range(0, 1));
      if (busy && ($urandom_range(0, 7) == 0)) begin
        start = 1'b1;
        code  = 8'($urandom);
      end
    end
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
    end
  endtask

  task automatic run_cell(input logic [7:0] c, input logic [24:0] a, input logic [5:0] ct,
                          input int inject_at, input int limit, output int lat);
    int d0, k;
    d0 = dut_dones;
    addr_log.delete();
    code = c; attr_in = a; ctrl_in = ct; start = 1'b1;
    step();
    k = 0;
    while ((dut_dones == d0) && (k < limit)) begin
      if (k == inject_at) begin
        code  = ~c;
        start = 1'b1;
      end
      step();
      k++;
    end
    chk("cell_done_once", dut_dones, d0 + 1);
    chk("cell_rows", m_rows, ROWS);
    lat = m_done_cyc - m_start_cyc;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bad, k, d0;
    logic [24:0] ra;
    logic [7:0]  rc;

    @(negedge clk);
    chk("reset_sty_ctrl_lit", sty_ctrl, 6'h3C);
    repeat (2) step();
    rst_n = 1'b1;

    // Frame counter phases, idle cell
    pulse_ticks(16);
    @(negedge clk);
    chk("tick16_blink", {sty_blink, sty_cursor}, 2'b10);
    pulse_ticks(16);
    @(negedge clk);
    chk("tick32_cursor", {sty_blink, sty_cursor}, 2'b01);
    pulse_ticks(224);
    @(negedge clk);
    chk("tick256_wrap", {sty_faint, sty_blink, sty_cursor}, 3'b000);

    // Basic cell, zero-wait font and sink
    run_cell(8'h41, 25'h0, 6'h15, -1, 200, lat);
    chk("basic_latency", lat, 48);
    bad = 0;
    foreach (addr_log[i]) if (addr_log[i] != 12'h410 + 12'(i)) bad++;
    chk("basic_addr_seq", bad, 0);
    chk("basic_addr_last", addr_log[addr_log.size() - 1], 12'h41F);

    // Sink stalls row 3 for five cycles
    bp_row = 3; bp_len = 5;
    run_cell(8'h5A, 25'h0, 6'h09, -1, 200, lat);
    chk("bp_latency", lat, 53);
    bp_row = -1;

    // Slow font, stray acks, and a start attempt mid-cell
    ack_delay = 4; stray_ack = 1'b1;
    run_cell(8'hC3, 25'h0A_5A5A, 6'h3F, 5, 400, lat);
    chk("slow_latency", lat, 112);
    bad = 0;
    foreach (addr_log[i]) if (addr_log[i][11:4] != 8'hC3) bad++;
    chk("slow_addr_code", bad, 0);
    chk("slow_fetches", addr_log.size(), ROWS);
    ack_delay = 0; stray_ack = 1'b0;

    // Reset while row 7 waits in OUT
    bp_row = 7; bp_len = 100000;
    code = 8'h33; attr_in = '0; ctrl_in = 6'h2A; start = 1'b1;
    step();
    k = 0;
    while (!(bus.out_valid && (bus.out_row == 4'd7)) && (k < 200)) begin
      step();
      k++;
    end
    chk("row7_reached", (k < 200), 1);
    @(negedge clk);
    #2;
    d0 = dut_dones;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_font_req", bus.font_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sty_ctrl", sty_ctrl, 6'h3C);
    repeat (3) step();
    rst_n = 1'b1;
    bp_row = -1;
    chk("abort_no_done", dut_dones, d0);
    run_cell(8'h77, 25'h0, 6'h01, -1, 200, lat);
    chk("post_reset_latency", lat, 48);
    chk("post_reset_first_addr", addr_log[0], 12'h770);

    // Randomized cells with random waits, ticks, stray acks and ignored starts
    rand_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ack_delay = $urandom_range(0, 3);
      ra = 25'($urandom);
      rc = 8'($urandom);
      run_cell(rc, ra, 6'($urandom), -1, 3000, lat);
    end
    rand_en = 1'b0;
    rdy_base = 1'b1;
    stray_ack = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
